// File: rtl/gf180mcu_osu_sc_seq_pkg.sv
// Shared types and helpers for the buffer-leg drive-strength sequencer.
// Holds the FSM state enum, the strength-width helper and the target clamp.
package gf180mcu_osu_sc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    SETTLE,
    FIN
  } seq_state_e;

  function automatic int strength_width(input int nlegs);
    return $clog2(nlegs + 1);
  endfunction

  // Timer must hold the larger of the two reload values (cycles - 1), at least 1 bit.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  function automatic int clamp_tgt(input int tgt, input int nlegs);
    return (tgt > nlegs) ? nlegs : tgt;
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3_step_timer.sv
// Loadable down-counter with a zero flag; stops at zero until reloaded.
module gf180mcu_osu_sc_gp12t3v3_step_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3_buf_leg_seq.sv
// Drive-strength sequencer: ramps thermometer leg enables one leg per step toward a target.
// Define GF180_BUF_LEG_SEQ_RETARGET_EN to accept new requests mid-ramp.
module gf180mcu_osu_sc_gp12t3v3_buf_leg_seq
  import gf180mcu_osu_sc_seq_pkg::*;
#(
  parameter int  NLEGS         = 4,
  parameter int  STEP_CYCLES   = 4,
  parameter int  SETTLE_CYCLES = 2,
  localparam int LW            = strength_width(NLEGS)
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             REQ,
  input  logic [LW-1:0]    TGT,
  output logic             ACK,
  output logic [NLEGS-1:0] EN,
  output logic [LW-1:0]    LEVEL,
  output logic             BUSY,
  output logic             DONE
);

  localparam int            TW          = timer_width(STEP_CYCLES, SETTLE_CYCLES);
  localparam logic [TW-1:0] STEP_LOAD   = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  seq_state_e       state_q, state_d;
  logic [LW-1:0]    tgt_q, tgt_d;
  logic [LW-1:0]    level_q, level_d;
  logic [NLEGS-1:0] en_q, en_d;
  logic             ack_q, ack_d, busy_q, busy_d, done_q, done_d;
  logic             step_load, step_dec, step_zero;
  logic             settle_load, settle_dec, settle_zero;
  logic             accept_ok;

`ifdef GF180_BUF_LEG_SEQ_RETARGET_EN
  assign accept_ok = (state_q == IDLE) || (state_q == STEP) || (state_q == SETTLE);
`else
  assign accept_ok = (state_q == IDLE);
`endif

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    level_d     = level_q;
    ack_d       = 1'b0;
    done_d      = 1'b0;
    busy_d      = (state_q == STEP) || (state_q == SETTLE);
    step_load   = 1'b0;
    step_dec    = 1'b0;
    settle_load = 1'b0;
    settle_dec  = 1'b0;

    case (state_q)
      STEP: begin
        if (step_zero) begin
          step_load = 1'b1;
          if (level_q < tgt_q) begin
            level_d = level_q + LW'(1);
          end else if (level_q > tgt_q) begin
            level_d = level_q - LW'(1);
          end
          if (level_d == tgt_q) begin
            // An unchanged target skips settling; a real ramp settles if configured.
            if ((level_q == tgt_q) || (SETTLE_CYCLES == 0)) begin
              state_d = FIN;
            end else begin
              state_d     = SETTLE;
              settle_load = 1'b1;
            end
          end
        end else begin
          step_dec = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_zero) begin
          state_d = FIN;
        end else begin
          settle_dec = 1'b1;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (REQ && accept_ok) begin
      ack_d     = 1'b1;
      tgt_d     = LW'(clamp_tgt(int'(TGT), NLEGS));
      step_load = 1'b1;
      state_d   = STEP;
    end

    en_d = ~({NLEGS{1'b1}} << level_d);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      level_q <= '0;
      en_q    <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      level_q <= level_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  gf180mcu_osu_sc_gp12t3v3_step_timer #(.W(TW)) u_step_timer (
    .clk        (CLK),
    .rst_n      (RN),
    .load_i     (step_load),
    .load_val_i (STEP_LOAD),
    .dec_i      (step_dec),
    .zero_o     (step_zero)
  );

  gf180mcu_osu_sc_gp12t3v3_step_timer #(.W(TW)) u_settle_timer (
    .clk        (CLK),
    .rst_n      (RN),
    .load_i     (settle_load),
    .load_val_i (SETTLE_LOAD),
    .dec_i      (settle_dec),
    .zero_o     (settle_zero)
  );

  assign ACK   = ack_q;
  assign EN    = en_q;
  assign LEVEL = level_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3_buf_leg_seq.sv
// Self-checking bench for the buffer-leg sequencer (NLEGS=4, STEP=4, SETTLE=2).
// Define GF180_BUF_LEG_SEQ_RETARGET_EN to exercise the mid-ramp retarget sequence.
module tb_gf180mcu_osu_sc_gp12t3v3_buf_leg_seq;

  localparam int NLEGS         = 4;
  localparam int STEP_CYCLES   = 4;
  localparam int SETTLE_CYCLES = 2;
  localparam int LW            = 3;

  logic             CLK = 1'b0;
  logic             RN, REQ, ACK, BUSY, DONE;
  logic [LW-1:0]    TGT, LEVEL;
  logic [NLEGS-1:0] EN;

  always #5 CLK = ~CLK;

  gf180mcu_osu_sc_gp12t3v3_buf_leg_seq #(
    .NLEGS         (NLEGS),
    .STEP_CYCLES   (STEP_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .CLK   (CLK),
    .RN    (RN),
    .REQ   (REQ),
    .TGT   (TGT),
    .ACK   (ACK),
    .EN    (EN),
    .LEVEL (LEVEL),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  typedef struct {
    logic             ack;
    logic [NLEGS-1:0] en;
    logic [LW-1:0]    level;
    logic             busy;
    logic             done;
  } exp_t;

  typedef struct {
    int tgt;
    int expLevel;
  } vec_t;

  exp_t sbQ[$];
  int   passCount  = 0;
  int   checkCount = 0;
  int   modelLevel = 0;

  function automatic logic [NLEGS-1:0] therm(input int n);
    logic [NLEGS-1:0] t;
    t = '0;
    for (int i = 0; i < NLEGS; i++) begin
      if (i < n) t[i] = 1'b1;
    end
    return t;
  endfunction

  function automatic exp_t mk(input logic ack, input int lvl, input logic busy, input logic done);
    exp_t e;
    e.ack   = ack;
    e.en    = therm(lvl);
    e.level = LW'(lvl);
    e.busy  = busy;
    e.done  = done;
    return e;
  endfunction

  // Expected level c cycles after ACK: one leg per STEP_CYCLES until the target is reached.
  function automatic int lvlAt(input int startLvl, input int finLvl, input int c);
    int k, steps;
    k     = (finLvl > startLvl) ? finLvl - startLvl : startLvl - finLvl;
    steps = c / STEP_CYCLES;
    if (steps > k) steps = k;
    return (finLvl >= startLvl) ? startLvl + steps : startLvl - steps;
  endfunction

  task automatic checkOutput(input string name, input exp_t e);
    checkCount++;
    if (ACK === e.ack && EN === e.en && LEVEL === e.level && BUSY === e.busy && DONE === e.done) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got ack=%0b en=%b level=%0d busy=%0b done=%0b, expected ack=%0b en=%b level=%0d busy=%0b done=%0b",
               name, ACK, EN, LEVEL, BUSY, DONE, e.ack, e.en, e.level, e.busy, e.done);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int expv);
    checkCount++;
    if (got == expv) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  // Drives a request and checks the ACK cycle; hold keeps REQ asserted afterwards.
  task automatic applyStimulus(input int tgt, input bit hold, input bit expBusy);
    @(negedge CLK);
    REQ = 1'b1;
    TGT = LW'(tgt);
    @(posedge CLK);
    #1;
    checkOutput($sformatf("ack_tgt%0d", tgt), mk(1'b1, modelLevel, expBusy, 1'b0));
    if (!hold) REQ = 1'b0;
  endtask

  // Queues the expected trajectory after ACK, then pops and compares one entry per cycle.
  task automatic followRequest(input int tgt, input int stopAt);
    int   startLvl, finLvl, k, doneCyc, last;
    exp_t e;
    startLvl = modelLevel;
    finLvl   = (tgt > NLEGS) ? NLEGS : tgt;
    k        = (finLvl > startLvl) ? finLvl - startLvl : startLvl - finLvl;
    doneCyc  = (k == 0) ? STEP_CYCLES + 1 : k * STEP_CYCLES + SETTLE_CYCLES + 1;
    last     = (stopAt > 0) ? stopAt : doneCyc;
    for (int c = 1; c <= last; c++) begin
      sbQ.push_back(mk(1'b0, lvlAt(startLvl, finLvl, c), c < doneCyc, c == doneCyc));
    end
    for (int c = 1; c <= last; c++) begin
      @(posedge CLK);
      #1;
      e = sbQ.pop_front();
      checkOutput($sformatf("tgt%0d_from%0d_c%0d", tgt, startLvl, c), e);
    end
    modelLevel = lvlAt(startLvl, finLvl, last);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{tgt: 4, expLevel: 4};
    vecs[1] = '{tgt: 1, expLevel: 1};
    vecs[2] = '{tgt: 7, expLevel: 4};
    vecs[3] = '{tgt: 4, expLevel: 4};
    vecs[4] = '{tgt: 0, expLevel: 0};
    vecs[5] = '{tgt: 3, expLevel: 3};

    RN  = 1'b0;
    REQ = 1'b0;
    TGT = '0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_state", mk(1'b0, 0, 1'b0, 1'b0));
    @(negedge CLK);
    RN = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].tgt, 1'b0, 1'b0);
      followRequest(vecs[i].tgt, 0);
      checkValue($sformatf("final_level_vec%0d", i), int'(LEVEL), vecs[i].expLevel);
    end

`ifndef GF180_BUF_LEG_SEQ_RETARGET_EN
    // REQ held through a ramp is ignored until the cycle after DONE.
    applyStimulus(1, 1'b1, 1'b0);
    followRequest(1, 0);
    @(posedge CLK);
    #1;
    checkOutput("held_req_reack", mk(1'b1, 1, 1'b0, 1'b0));
    REQ = 1'b0;
    followRequest(1, 0);
`endif

    // Async reset at cycle 9 of a 0->4 ramp drops all legs immediately.
    applyStimulus(0, 1'b0, 1'b0);
    followRequest(0, 0);
    applyStimulus(4, 1'b0, 1'b0);
    followRequest(4, 8);
    @(posedge CLK);
    #2;
    RN = 1'b0;
    #1;
    checkOutput("async_reset_midramp", mk(1'b0, 0, 1'b0, 1'b0));
    @(negedge CLK);
    RN = 1'b1;
    modelLevel = 0;
    applyStimulus(1, 1'b0, 1'b0);
    followRequest(1, 0);
    checkValue("level_after_reset_ramp", int'(LEVEL), 1);

`ifdef GF180_BUF_LEG_SEQ_RETARGET_EN
    // Retarget to 0 at LEVEL=2 during a 0->4 ramp; only the final request completes.
    applyStimulus(0, 1'b0, 1'b0);
    followRequest(0, 0);
    applyStimulus(4, 1'b0, 1'b0);
    followRequest(4, 8);
    applyStimulus(0, 1'b0, 1'b1);
    followRequest(0, 0);
    checkValue("level_after_retarget", int'(LEVEL), 0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3_buf_leg_seq.md
Name: gf180mcu_osu_sc_gp12t3v3_buf_leg_seq

Overview:
- Drive-strength sequencer for a segmented output buffer built from parallel buf legs. Each leg is a buf_1-equivalent finger; all legs on gives buf_4 strength when NLEGS=4.
- Accepts a target strength via a req/ack handshake and ramps the leg enables one leg per step, limiting di/dt and supply bounce.
- Sits between the pad/clock-tree control logic and the leg-enable pins of the segmented buffer macro.

Parameters:
- NLEGS, 4, number of parallel buffer legs; range 1..16.
- STEP_CYCLES, 4, CLK cycles between successive leg changes; must be >= 1.
- SETTLE_CYCLES, 2, CLK cycles held after the final leg change before DONE; 0 is allowed.
- LW (localparam), $clog2(NLEGS+1), width of strength values.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RN  input  1  asynchronous, active-low reset.
- REQ  input  1  strength-change request.
- TGT  input  LW  requested number of enabled legs; sampled on accept.
- ACK  output  1  one-cycle accept pulse.
- EN  output  NLEGS  thermometer leg enables; EN[0] is always the first leg on and the last leg off.
- LEVEL  output  LW  current count of enabled legs; always equals popcount(EN).
- BUSY  output  1  high from the cycle after accept until DONE is asserted.
- DONE  output  1  one-cycle completion pulse.

Behaviour:
- Reset (RN low, asynchronous):
  - state=IDLE, EN=0, LEVEL=0, ACK=0, BUSY=0, DONE=0, counters=0.
  - Reset asserted mid-ramp drops every leg immediately; there is no ramp-down.
- States: IDLE, STEP, SETTLE, FIN.
- IDLE:
  - If REQ=1, ACK=1 for that cycle, TGT is captured into tgt_q, the step counter loads STEP_CYCLES-1, and the next state is STEP.
  - TGT > NLEGS is clamped to NLEGS.
  - REQ is ignored outside IDLE; ACK stays 0 (unless RETARGET is enabled).
- STEP:
  - The counter decrements each cycle. At 0: if LEVEL<tgt_q, LEVEL+1 and set EN[LEVEL]; if LEVEL>tgt_q, LEVEL-1 and clear EN[LEVEL-1]. The counter then reloads.
  - When the update makes LEVEL==tgt_q, go to SETTLE, or to FIN if SETTLE_CYCLES=0.
  - If tgt_q==LEVEL at accept, no leg changes; STEP exits to FIN after STEP_CYCLES cycles.
- SETTLE: counts SETTLE_CYCLES cycles, then goes to FIN.
- FIN: DONE=1 for one cycle, BUSY=0, next state IDLE.
  - A REQ in the cycle after FIN is accepted normally, so back-to-back requests are legal.
- Latency:
  - For |tgt-LEVEL|=k>0, leg i of the ramp changes exactly i*STEP_CYCLES cycles after the ACK cycle.
  - DONE is asserted at k*STEP_CYCLES+SETTLE_CYCLES+1 cycles after ACK.
- Only one EN bit changes per clock, and EN is always thermometer-coded.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
- GF180_BUF_LEG_SEQ_RETARGET_EN defined:
  - REQ is also accepted in STEP and SETTLE: ACK=1, tgt_q updated, counter reloaded, state goes to STEP.
  - Ramp direction is re-evaluated at the next step boundary.
  - BUSY stays high; no DONE is issued for the superseded request.
- Undefined: REQ is accepted only in IDLE.

Decomposition:
- Shared package gf180mcu_osu_sc_seq_pkg holds:
  - state enum (IDLE, STEP, SETTLE, FIN);
  - a clamp function for TGT;
  - the LW width helper.
- One sub-module, gf180mcu_osu_sc_gp12t3v3_step_timer: a loadable down-counter with a zero flag, instantiated twice (step and settle).

Test Plan:
- Reset, then REQ/TGT=4, NLEGS=4, STEP=4, SETTLE=2 -> ACK at cycle 0; EN = 0001/0011/0111/1111 at cycles 4/8/12/16; DONE at cycle 19; BUSY high cycles 1-18.
- From LEVEL=4, REQ/TGT=1 -> EN = 0111/0011/0001 at +4/+8/+12; DONE at +15; LEVEL=1.
- TGT=7 with NLEGS=4 -> clamped, ends at EN=1111, LEVEL=4; TGT=LEVEL -> no EN change, DONE at +5.
- REQ held high during a ramp (macro off) -> no ACK until after DONE; the next ACK comes the cycle after FIN.
- RN pulled low at cycle 9 of a 0->4 ramp -> EN=0000, BUSY=0 asynchronously; the next request after release starts from LEVEL=0.
- Macro on: during a 0->4 ramp, at LEVEL=2 issue REQ/TGT=0 -> ACK, EN=0001 after 4 cycles, 0000 after 8; exactly one DONE.
